misr_bist_ctrl: RTL and testbench

- Downstream BIST stage: consumes circuit-under-test (CUT) responses to patterns from the scan-seeded 4-bit pattern-generator LFSR.
- Compacts responses into a Multiple-Input Signature Register (MISR) over a fixed pattern count, then compares against a golden signature.
- Also sequences the run: resets the generator, enables it, counts patterns and reports pass/fail.

---
 rtl/bist_pkg.sv | 27 ++
 rtl/misr_core.sv | 44 ++++
 rtl/misr_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_misr_bist_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller states, default generator geometry, MISR step.
package bist_pkg;

   localparam int unsigned NBIT_DEF  = 4;
   localparam int unsigned MISR_MAXW = 32;
   localparam logic [NBIT_DEF-1:0] TAPS_DEF = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_CHECK,
      ST_DONE
   } bist_state_e;

   // One MISR step on zero-extended operands; the caller truncates to its own width.
   function automatic logic [MISR_MAXW-1:0] misr_next(
      input logic [MISR_MAXW-1:0] sig,
      input logic [MISR_MAXW-1:0] resp,
      input logic [MISR_MAXW-1:0] taps
   );
      logic fb;
      fb = ^(sig & taps);
      return {sig[MISR_MAXW-2:0], fb} ^ resp;
   endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: seed load has priority over compaction.
module misr_core
   import bist_pkg::*;
#(
   parameter int unsigned     NBIT      = NBIT_DEF,
   parameter logic [NBIT-1:0] TAPS      = TAPS_DEF,
   parameter logic [NBIT-1:0] MISR_SEED = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            en,
   input  logic [NBIT-1:0] d,
   output logic [NBIT-1:0] q
);

   if (NBIT < 2 || NBIT > MISR_MAXW) begin : g_nbit_bad
      $error("misr_core: NBIT out of supported range");
   end

   logic [NBIT-1:0] sig_q, sig_d;

   // Next signature: reseed, compact one response, or hold.
   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = MISR_SEED;
      end else if (en) begin
         sig_d = NBIT'(misr_next(MISR_MAXW'(sig_q), MISR_MAXW'(d), MISR_MAXW'(TAPS)));
      end
   end

   // Signature register, synchronous reset to the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= MISR_SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign q = sig_q;

endmodule

// File: rtl/misr_bist_ctrl.sv
// BIST run sequencer: drives the pattern generator, compacts NPAT responses, checks the signature.
module misr_bist_ctrl
   import bist_pkg::*;
#(
   parameter int unsigned     NBIT      = NBIT_DEF,
   parameter int unsigned     NPAT      = 15,
   parameter int unsigned     CW        = 4,
   parameter logic [NBIT-1:0] TAPS      = TAPS_DEF,
   parameter logic [NBIT-1:0] MISR_SEED = '0,
   parameter logic [NBIT-1:0] GOLDEN    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            resp_valid,
   input  logic [NBIT-1:0] resp,
   output logic            gen_rst,
   output logic            gen_en,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [NBIT-1:0] signature,
   output logic [CW-1:0]   pat_cnt
);

   // The pattern counter must reach NPAT without wrapping.
   if (NPAT == 0 || NPAT > (2 ** CW) - 1) begin : g_npat_bad
      $error("misr_bist_ctrl: NPAT must be in 1..2^CW-1");
   end

   bist_state_e   state_q, state_d;
   logic [CW-1:0] pat_cnt_q, pat_cnt_d;
   logic          pass_q, pass_d;
   logic          gen_rst_q, gen_rst_d;
   logic          gen_en_q, gen_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          misr_load, misr_en;
   logic          cnt_full;
   logic [NBIT-1:0] sig;

   assign cnt_full = (pat_cnt_q == CW'(NPAT));

   // Next state, counter, pass flag and state-decoded outputs (registered off the next state).
   always_comb begin
      state_d   = state_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_INIT;
               pass_d  = 1'b0;
            end
         end
         ST_INIT: begin
            misr_load = 1'b1;
            pat_cnt_d = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // RUN is left once the counter holds NPAT; no response is taken in that cycle.
            if (cnt_full) begin
               state_d = ST_CHECK;
            end else if (resp_valid) begin
               misr_en   = 1'b1;
               pat_cnt_d = pat_cnt_q + CW'(1);
            end
         end
         ST_CHECK: begin
            pass_d  = (sig == GOLDEN);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_INIT;
               pass_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      gen_rst_d = (state_d == ST_IDLE) || (state_d == ST_INIT);
      gen_en_d  = (state_d == ST_RUN);
      busy_d    = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_CHECK);
      done_d    = (state_d == ST_DONE);
   end

   // Control state and output registers; reset holds the generator at its seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
         gen_rst_q <= 1'b1;
         gen_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_cnt_q <= pat_cnt_d;
         pass_q    <= pass_d;
         gen_rst_q <= gen_rst_d;
         gen_en_q  <= gen_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   misr_core #(
      .NBIT      (NBIT),
      .TAPS      (TAPS),
      .MISR_SEED (MISR_SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load),
      .en   (misr_en),
      .d    (resp),
      .q    (sig)
   );

   assign gen_rst   = gen_rst_q;
   assign gen_en    = gen_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig;
   assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Bench for misr_bist_ctrl: three instances (NPAT=2 golden 0011, NPAT=2 golden 0000, defaults) share stimulus.
module tb_misr_bist_ctrl;

   localparam int NDUT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       resp_valid;
   logic [3:0] resp;

   logic       gen_rst_o [NDUT];
   logic       gen_en_o  [NDUT];
   logic       busy_o    [NDUT];
   logic       done_o    [NDUT];
   logic       pass_o    [NDUT];
   logic [3:0] sig_o     [NDUT];
   logic [3:0] cnt_o     [NDUT];

   int         npat_m   [NDUT];
   logic [3:0] golden_m [NDUT];

   int         obs_done_k [NDUT];
   logic [3:0] obs_sig    [NDUT];
   logic       obs_pass   [NDUT];
   logic [3:0] obs_cnt    [NDUT];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   misr_bist_ctrl #(.NPAT(2), .GOLDEN(4'b0011)) u_a (
      .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
      .gen_rst(gen_rst_o[0]), .gen_en(gen_en_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .pass(pass_o[0]), .signature(sig_o[0]), .pat_cnt(cnt_o[0])
   );

   misr_bist_ctrl #(.NPAT(2), .GOLDEN(4'b0000)) u_b (
      .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
      .gen_rst(gen_rst_o[1]), .gen_en(gen_en_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .pass(pass_o[1]), .signature(sig_o[1]), .pat_cnt(cnt_o[1])
   );

   misr_bist_ctrl u_d (
      .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
      .gen_rst(gen_rst_o[2]), .gen_en(gen_en_o[2]), .busy(busy_o[2]), .done(done_o[2]),
      .pass(pass_o[2]), .signature(sig_o[2]), .pat_cnt(cnt_o[2])
   );

   // Reference MISR step: shift left, feedback = parity of the tapped bits 3 and 2, then XOR the response.
   function automatic logic [3:0] ref_misr(input logic [3:0] s, input logic [3:0] r);
      logic fb;
      fb = ($countones(s & 4'b1100) % 2) == 1;
      return {s[2:0], fb} ^ r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = 4'b0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         resp_valid = 1'($urandom_range(0, 1));
         resp       = 4'($urandom);
         @(negedge clk);
         for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({gen_rst_o[i], gen_en_o[i], busy_o[i], done_o[i], pass_o[i]} !== 5'b10000) begin
               failures++;
               $display("FAIL reset_flags dut%0d cyc%0d: got %b want 10000", i, c,
                        {gen_rst_o[i], gen_en_o[i], busy_o[i], done_o[i], pass_o[i]});
            end
            checks++;
            if (sig_o[i] !== 4'b0000 || cnt_o[i] !== 4'd0) begin
               failures++;
               $display("FAIL reset_regs dut%0d cyc%0d: got sig=%b cnt=%0d want sig=0000 cnt=0",
                        i, c, sig_o[i], cnt_o[i]);
            end
         end
      end
   endtask

   // vmode: 0 continuous valid, 1 random valid, 2 valid pattern 1,0,0,1 then continuous.
   task automatic test_run(input int vmode, input bit rrand, input logic [3:0] rfix);
      int         q_cnt  [NDUT];
      int         full_k [NDUT];
      logic [3:0] m_sig  [NDUT];
      int         k;
      bit         fin;
      logic       exp_done;
      logic       exp_en;
      for (int i = 0; i < NDUT; i++) begin
         q_cnt[i] = 0; full_k[i] = -1; m_sig[i] = 4'b0000; obs_done_k[i] = -1;
      end
      start = 1'b1; resp_valid = 1'($urandom_range(0, 1)); resp = 4'($urandom);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if ({busy_o[i], gen_rst_o[i], gen_en_o[i], done_o[i], pass_o[i]} !== 5'b11000) begin
            failures++;
            $display("FAIL init_flags dut%0d: got %b want 11000", i,
                     {busy_o[i], gen_rst_o[i], gen_en_o[i], done_o[i], pass_o[i]});
         end
      end
      k = 0;
      fin = 1'b0;
      while (!fin && k < 300) begin
         if (k == 0) begin
            resp_valid = 1'b1;
            resp       = 4'($urandom);
         end else begin
            case (vmode)
               0:       resp_valid = 1'b1;
               1:       resp_valid = ($urandom_range(0, 3) != 0);
               default: resp_valid = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            endcase
            resp = rrand ? 4'($urandom) : rfix;
         end
         for (int i = 0; i < NDUT; i++) begin
            if (k >= 1 && q_cnt[i] < npat_m[i] && resp_valid) begin
               m_sig[i] = ref_misr(m_sig[i], resp);
               q_cnt[i]++;
               if (q_cnt[i] == npat_m[i]) full_k[i] = k + 1;
            end
         end
         @(negedge clk);
         k++;
         fin = 1'b1;
         for (int i = 0; i < NDUT; i++) begin
            exp_done = (full_k[i] >= 0 && k >= full_k[i] + 2);
            exp_en   = (full_k[i] < 0 || k <= full_k[i]);
            checks++;
            if (sig_o[i] !== m_sig[i]) begin
               failures++;
               $display("FAIL run_sig dut%0d k%0d: got %b want %b", i, k, sig_o[i], m_sig[i]);
            end
            checks++;
            if (cnt_o[i] !== 4'(q_cnt[i])) begin
               failures++;
               $display("FAIL run_cnt dut%0d k%0d: got %0d want %0d", i, k, cnt_o[i], q_cnt[i]);
            end
            checks++;
            if ({done_o[i], busy_o[i], gen_en_o[i]} !== {exp_done, ~exp_done, exp_en}) begin
               failures++;
               $display("FAIL run_flags dut%0d k%0d: got done/busy/gen_en=%b want %b", i, k,
                        {done_o[i], busy_o[i], gen_en_o[i]}, {exp_done, ~exp_done, exp_en});
            end
            checks++;
            if (pass_o[i] !== (exp_done && m_sig[i] == golden_m[i])) begin
               failures++;
               $display("FAIL run_pass dut%0d k%0d: got %b want %b", i, k, pass_o[i],
                        (exp_done && m_sig[i] == golden_m[i]));
            end
            if (exp_en) begin
               checks++;
               if (gen_rst_o[i] !== 1'b0) begin
                  failures++;
                  $display("FAIL run_gen_rst dut%0d k%0d: got %b want 0", i, k, gen_rst_o[i]);
               end
            end
            if (done_o[i] === 1'b1 && obs_done_k[i] < 0) obs_done_k[i] = k;
            if (!(full_k[i] >= 0 && k >= full_k[i] + 4)) fin = 1'b0;
         end
      end
      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL run_timeout: got no completion within %0d cycles want completion", k);
      end
      for (int i = 0; i < NDUT; i++) begin
         obs_sig[i] = sig_o[i]; obs_pass[i] = pass_o[i]; obs_cnt[i] = cnt_o[i];
      end
   endtask

   task automatic test_ones(input string tag);
      test_run(0, 1'b0, 4'b0001);
      checks++;
      if (obs_sig[0] !== 4'b0011) begin
         failures++;
         $display("FAIL %s_sig: got %b want 0011", tag, obs_sig[0]);
      end
      checks++;
      if (obs_done_k[0] != 5) begin
         failures++;
         $display("FAIL %s_done_latency: got %0d want 5", tag, obs_done_k[0]);
      end
      checks++;
      if (obs_pass[0] !== 1'b1 || obs_pass[1] !== 1'b0) begin
         failures++;
         $display("FAIL %s_pass: got a=%b b=%b want a=1 b=0", tag, obs_pass[0], obs_pass[1]);
      end
      checks++;
      if (obs_done_k[2] != 18) begin
         failures++;
         $display("FAIL %s_done_latency_default: got %0d want 18", tag, obs_done_k[2]);
      end
   endtask

   task automatic test_zero_default();
      test_run(0, 1'b0, 4'b0000);
      checks++;
      if (obs_sig[2] !== 4'b0000 || obs_cnt[2] !== 4'd15 || obs_pass[2] !== 1'b1) begin
         failures++;
         $display("FAIL zero_default: got sig=%b cnt=%0d pass=%b want sig=0000 cnt=15 pass=1",
                  obs_sig[2], obs_cnt[2], obs_pass[2]);
      end
   endtask

   task automatic test_gapped();
      test_run(2, 1'b0, 4'b0001);
      checks++;
      if (obs_sig[0] !== 4'b0011) begin
         failures++;
         $display("FAIL gapped_sig: got %b want 0011", obs_sig[0]);
      end
      checks++;
      if (obs_done_k[0] != 7) begin
         failures++;
         $display("FAIL gapped_done_latency: got %0d want 7", obs_done_k[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) test_run(1, 1'b1, 4'b0000);
   endtask

   task automatic test_abort();
      logic [3:0] e;
      e = 4'b0000;
      repeat (3) e = ref_misr(e, 4'b0001);
      start = 1'b1; resp_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      resp_valid = 1'b1; resp = 4'b0001;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (cnt_o[2] !== 4'd3 || sig_o[2] !== e || busy_o[2] !== 1'b1) begin
         failures++;
         $display("FAIL abort_start_ignored: got cnt=%0d sig=%b busy=%b want cnt=3 sig=%b busy=1",
                  cnt_o[2], sig_o[2], busy_o[2], e);
      end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({gen_rst_o[i], gen_en_o[i], busy_o[i], done_o[i], pass_o[i]} !== 5'b10000 ||
                sig_o[i] !== 4'b0000 || cnt_o[i] !== 4'd0) begin
               failures++;
               $display("FAIL abort_reset dut%0d cyc%0d: got flags=%b sig=%b cnt=%0d want flags=10000 sig=0000 cnt=0",
                        i, c, {gen_rst_o[i], gen_en_o[i], busy_o[i], done_o[i], pass_o[i]},
                        sig_o[i], cnt_o[i]);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      npat_m   = '{2, 2, 15};
      golden_m = '{4'b0011, 4'b0000, 4'b0000};
      test_reset();
      test_ones("ones");
      test_ones("rerun");
      test_zero_default();
      test_gapped();
      test_random();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

endmodule
